// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the internal module register bus:
//                command byte field positions, IOC width, initiator state
//                encoding and the read value returned for absent responders.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

    // Command byte layout: {dir, module index[1:0], ioc[4:0]}
    localparam int DIR_BIT = 7;
    localparam int IDX_MSB = 6;
    localparam int IDX_LSB = 5;
    localparam int IOC_W   = 5;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    // Data handed back when a read targets a module that does not exist
    localparam logic [7:0] RD_INVALID_DATA = 8'h00;

    // Initiator state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_LOAD      = 3'd2,
        ST_FETCH     = 3'd3,
        ST_WAIT_RD   = 3'd4,
        ST_TX        = 3'd5
    } bus_state_t;

    // True when a module index addresses a populated responder slot
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                          input int n_modules);
        return (int'(idx) < n_modules);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_initiator
//  Description : Decodes command/data bytes from the SPI byte receiver and
//                issues single-cycle load/fetch strobes with IOC address and
//                one-hot chip-select to up to four register-file responders.
//                Read data is captured and returned to the SPI byte
//                transmitter through a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module io_bus_initiator
    import bus_pkg::*;
#(
    parameter int N_MODULES = 4,
    parameter int READ_LAT  = 1
) (
    input  logic                   i_sys_clk,
    input  logic                   i_rst,
    input  logic                   i_frame,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_byte,
    output logic [7:0]             o_tx_byte,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [IOC_W-1:0]       o_ioc,
    output logic [7:0]             o_data_out,
    output logic [N_MODULES-1:0]   o_cs,
    output logic                   o_fetch_cmd,
    output logic                   o_load_cmd,
    input  logic [8*N_MODULES-1:0] i_data_in,
    output logic                   o_busy,
    output logic                   o_err
);

    bus_state_t r_state;
    bus_state_t w_next_state;

    logic [IDX_W-1:0]     r_idx;
    logic [IOC_W-1:0]     r_ioc;
    logic [7:0]           r_data_out;
    logic [7:0]           r_tx_byte;
    logic [1:0]           r_lat_cnt;
    logic                 r_err;
    logic                 r_tx_valid;
    logic                 r_busy;
    logic                 r_load;
    logic                 r_fetch;
    logic [N_MODULES-1:0] r_cs;

    logic                 w_cmd_accept;
    logic                 w_data_accept;
    logic                 w_lat_done;
    logic [IDX_W-1:0]     w_cmd_idx;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_sel_valid;
    logic [N_MODULES-1:0] w_cs_onehot;
    logic [7:0]           w_rd_data;
    logic                 w_load_nxt;
    logic                 w_fetch_nxt;
    logic [N_MODULES-1:0] w_cs_nxt;
    logic                 w_tx_valid_nxt;
    logic                 w_busy_nxt;

    // While the frame is closed no byte is accepted at all
    assign w_cmd_accept  = (r_state == ST_IDLE)      && i_frame && i_rx_valid;
    assign w_data_accept = (r_state == ST_WAIT_DATA) && i_frame && i_rx_valid;
    assign w_lat_done    = (r_lat_cnt == 2'(READ_LAT - 1));
    assign w_cmd_idx     = i_rx_byte[IDX_MSB:IDX_LSB];

    // A fetch strobe is launched from IDLE, before r_idx holds the new index
    assign w_sel_idx   = (r_state == ST_IDLE) ? w_cmd_idx : r_idx;
    assign w_sel_valid = idx_in_range(w_sel_idx, N_MODULES);

    // One-hot decode of the selected module index
    always_comb begin
        w_cs_onehot = '0;
        for (int k = 0; k < N_MODULES; k++) begin
            w_cs_onehot[k] = (w_sel_idx == IDX_W'(k));
        end
    end

    // Read-data mux: byte lane of the latched responder index
    always_comb begin
        w_rd_data = RD_INVALID_DATA;
        for (int k = 0; k < N_MODULES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_rd_data = i_data_in[8*k +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a closed frame always returns to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_accept) begin
                    w_next_state = i_rx_byte[DIR_BIT] ? ST_WAIT_DATA : ST_FETCH;
                end
            end
            ST_WAIT_DATA: begin
                if (w_data_accept) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD:    w_next_state = ST_IDLE;
            ST_FETCH:   w_next_state = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (w_lat_done) begin
                    w_next_state = ST_TX;
                end
            end
            ST_TX: begin
                if (i_tx_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:    w_next_state = ST_IDLE;
        endcase
        if (!i_frame) begin
            w_next_state = ST_IDLE;
        end
    end

    // Output decode from the next state so every output comes from a flop
    always_comb begin
        w_load_nxt     = (w_next_state == ST_LOAD)  && w_sel_valid;
        w_fetch_nxt    = (w_next_state == ST_FETCH) && w_sel_valid;
        w_cs_nxt       = (w_load_nxt || w_fetch_nxt) ? w_cs_onehot : '0;
        w_tx_valid_nxt = (w_next_state == ST_TX);
        w_busy_nxt     = (w_next_state != ST_IDLE);
    end

    // Command latch, write data, read latency counter, capture and error flag
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_idx      <= '0;
            r_ioc      <= '0;
            r_data_out <= '0;
            r_tx_byte  <= '0;
            r_lat_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_idx <= w_cmd_idx;
                r_ioc <= i_rx_byte[IOC_W-1:0];
                if (!idx_in_range(w_cmd_idx, N_MODULES)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_data_accept) begin
                r_data_out <= i_rx_byte;
            end
            if (r_state == ST_WAIT_RD) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end else begin
                r_lat_cnt <= '0;
            end
            if ((r_state == ST_WAIT_RD) && w_lat_done && i_frame) begin
                r_tx_byte <= w_sel_valid ? w_rd_data : RD_INVALID_DATA;
            end
        end
    end

    // Registered strobes, select and handshake outputs
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_load     <= 1'b0;
            r_fetch    <= 1'b0;
            r_cs       <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_load     <= w_load_nxt;
            r_fetch    <= w_fetch_nxt;
            r_cs       <= w_cs_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign o_tx_byte   = r_tx_byte;
    assign o_tx_valid  = r_tx_valid;
    assign o_ioc       = r_ioc;
    assign o_data_out  = r_data_out;
    assign o_cs        = r_cs;
    assign o_fetch_cmd = r_fetch;
    assign o_load_cmd  = r_load;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_initiator
//  Description : Self-checking bench for io_bus_initiator. Behavioural
//                responders hold register files and present read data only
//                READ_LAT cycles after a fetch; a transaction-level model
//                predicts every observable output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_bus_initiator;

    localparam int N   = 2;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame;
    logic           rx_valid;
    logic [7:0]     rx_byte;
    logic [7:0]     tx_byte;
    logic           tx_valid;
    logic           tx_ready;
    logic [4:0]     ioc;
    logic [7:0]     data_out;
    logic [N-1:0]   cs;
    logic           fetch_cmd;
    logic           load_cmd;
    logic [8*N-1:0] data_in;
    logic           busy;
    logic           err;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] exp_mem [N][32];
    logic       model_err;
    logic [7:0] model_dout;
    logic [4:0] model_ioc;

    // Responder environment
    logic [7:0] resp_mem [N][32];
    logic       tb_init;
    logic [3:0] fhist;

    io_bus_initiator #(.N_MODULES(N), .READ_LAT(LAT)) dut (
        .i_sys_clk  (clk),
        .i_rst      (rst),
        .i_frame    (frame),
        .i_rx_valid (rx_valid),
        .i_rx_byte  (rx_byte),
        .o_tx_byte  (tx_byte),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_ioc      (ioc),
        .o_data_out (data_out),
        .o_cs       (cs),
        .o_fetch_cmd(fetch_cmd),
        .o_load_cmd (load_cmd),
        .i_data_in  (data_in),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Responders: write on load strobe, remember fetch timing
    always @(posedge clk) begin
        fhist <= {fhist[2:0], fetch_cmd};
        if (tb_init) begin
            for (int k = 0; k < N; k++)
                for (int a = 0; a < 32; a++)
                    resp_mem[k][a] <= 8'(k * 32 + a + 1);
        end else if (load_cmd) begin
            for (int k = 0; k < N; k++)
                if (cs[k]) resp_mem[k][ioc] <= data_out;
        end
    end

    // Read data is only meaningful READ_LAT cycles after the fetch strobe
    always_comb begin
        for (int k = 0; k < N; k++)
            data_in[8*k +: 8] = fhist[LAT-1] ? resp_mem[k][ioc] : 8'hEE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_txv"},  32'(tx_valid),  0);
        chk({tag, "_txb"},  32'(tx_byte),   0);
        chk({tag, "_ioc"},  32'(ioc),       0);
        chk({tag, "_dout"}, 32'(data_out),  0);
        chk({tag, "_cs"},   32'(cs),        0);
        chk({tag, "_ld"},   32'(load_cmd),  0);
        chk({tag, "_fe"},   32'(fetch_cmd), 0);
        chk({tag, "_busy"}, 32'(busy),      0);
        chk({tag, "_err"},  32'(err),       0);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input int gap);
        logic [1:0] idx = cmd[6:5];
        logic [4:0] a   = cmd[4:0];
        logic       v   = (int'(idx) < N);
        if (!v) model_err = 1'b1;
        model_ioc = a;
        send(cmd);
        chk("wr_cmd_busy", 32'(busy), 1);
        chk("wr_cmd_ld",   32'(load_cmd), 0);
        chk("wr_cmd_ioc",  32'(ioc), 32'(model_ioc));
        chk("wr_cmd_err",  32'(err), 32'(model_err));
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("wr_gap_ld", 32'(load_cmd), 0);
        end
        send(data);
        model_dout = data;
        if (v) exp_mem[idx][a] = data;
        chk("wr_ld",   32'(load_cmd), 32'(v));
        chk("wr_cs",   32'(cs), v ? (32'(1) << idx) : 0);
        chk("wr_ioc",  32'(ioc), 32'(model_ioc));
        chk("wr_dout", 32'(data_out), 32'(model_dout));
        chk("wr_err",  32'(err), 32'(model_err));
        tick();
        chk("wr_end_ld",   32'(load_cmd), 0);
        chk("wr_end_cs",   32'(cs), 0);
        chk("wr_end_busy", 32'(busy), 0);
        chk("wr_end_ioc",  32'(ioc), 32'(model_ioc));
    endtask

    task automatic do_read(input logic [7:0] cmd, input int hold, input bit dummy, input bit rst_in_tx);
        logic [1:0] idx = cmd[6:5];
        logic [4:0] a   = cmd[4:0];
        logic       v   = (int'(idx) < N);
        logic [7:0] exp = 8'h00;
        if (v) exp = exp_mem[idx][a];
        if (!v) model_err = 1'b1;
        model_ioc = a;
        send(cmd);
        chk("rd_fetch", 32'(fetch_cmd), 32'(v));
        chk("rd_cs",    32'(cs), v ? (32'(1) << idx) : 0);
        chk("rd_busy",  32'(busy), 1);
        chk("rd_ioc",   32'(ioc), 32'(model_ioc));
        chk("rd_err",   32'(err), 32'(model_err));
        if (dummy) begin
            // Dummy byte carries an out-of-range index; must not set o_err
            rx_valid = 1'b1;
            rx_byte  = 8'h60 | 8'($urandom_range(0, 31));
        end
        for (int i = 0; i < LAT; i++) begin
            tick();
            rx_valid = 1'b0;
            chk("rd_wait_txv", 32'(tx_valid), 0);
            chk("rd_wait_fe",  32'(fetch_cmd), 0);
            chk("rd_wait_cs",  32'(cs), 0);
        end
        tick();
        chk("rd_txv",  32'(tx_valid), 1);
        chk("rd_txb",  32'(tx_byte), 32'(exp));
        chk("rd_err2", 32'(err), 32'(model_err));
        chk("rd_dout", 32'(data_out), 32'(model_dout));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rd_hold_txv", 32'(tx_valid), 1);
            chk("rd_hold_txb", 32'(tx_byte), 32'(exp));
        end
        if (rst_in_tx) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_err  = 1'b0;
            model_dout = 8'h00;
            model_ioc  = 5'h00;
            chk_all_zero("rst_tx");
        end else begin
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            chk("rd_rel_txv",  32'(tx_valid), 0);
            chk("rd_rel_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tb_init  = 1'b1;
        frame    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b0;
        model_err  = 1'b0;
        model_dout = 8'h00;
        model_ioc  = 5'h00;
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 32; a++)
                exp_mem[k][a] = 8'(k * 32 + a + 1);
        repeat (3) tick();
        tb_init = 1'b0;
        rst     = 1'b0;
        frame   = 1'b1;
        tick();
        chk_all_zero("reset");

        // Directed write: idx 1, ioc 2, data 5C
        do_write(8'hA2, 8'h5C, 1);
        // Directed read of responder 0 ioc 0, held 3 cycles
        do_read(8'h00, 3, 1'b0, 1'b0);
        // Read back the write
        do_read(8'h22, 0, 1'b0, 1'b0);

        // Invalid index read: sticky error, zero data
        do_read(8'h41, 1, 1'b0, 1'b0);
        tick();
        chk("err_sticky", 32'(err), 1);

        // Abort before the data byte
        send(8'h81);
        chk("ab_busy0", 32'(busy), 1);
        frame = 1'b0;
        tick();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_ld",   32'(load_cmd), 0);
        // Abort coinciding with a data byte: abort wins
        frame = 1'b1;
        send(8'h83);
        model_ioc = 5'h03;
        frame = 1'b0;
        send(8'h77);
        chk("ab2_ld",   32'(load_cmd), 0);
        chk("ab2_busy", 32'(busy), 0);
        chk("ab2_dout", 32'(data_out), 32'(model_dout));
        // Byte while frame is low is ignored
        send(8'h01);
        chk("ab3_busy", 32'(busy), 0);
        frame = 1'b1;
        tick();
        do_read(8'h01, 0, 1'b0, 1'b0);

        // Reset while tx valid, with a dummy byte during the read
        do_read(8'h03, 1, 1'b1, 1'b1);
        do_read(8'h25, 0, 1'b1, 1'b0);
        chk("dummy_err", 32'(err), 0);

        // Randomised traffic
        for (int t = 0; t < 30; t++) begin
            logic [7:0] c;
            c = 8'($urandom);
            if (c[7])
                do_write(c, 8'($urandom), int'($urandom_range(0, 3)));
            else
                do_read(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
